// File: rtl/instr_fetch_obi_pkg.sv
// rtl/instr_fetch_obi_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_obi_pkg;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_obi_fifo.sv
// rtl/instr_fetch_obi_fifo.sv - synchronous FIFO of fetch entries with flush and occupancy count
module fetch_fifo
  import instr_fetch_obi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_obi.sv
// rtl/instr_fetch_obi.sv - OBI instruction fetch initiator with credit-based issue and redirect flush
module instr_fetch_obi
  import instr_fetch_obi_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = BOOT_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_ready_i
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]    pc;
  logic [31:0]    pc_next;
  logic [31:0]    target;
  logic [31:0]    redirect_target;
  logic           pending_redirect;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  outstanding_next;
  logic [OW-1:0]  discard;
  logic [OW-1:0]  discard_next;
  logic [FCW-1:0] fifo_count;
  logic [FCW-1:0] fifo_count_next;
  logic           handshake;
  logic           hold;
  logic           resp;
  logic           fifo_push;
  logic           fifo_pop;
  logic           credit;
  logic           q_valid;
  logic [OW-1:0]  q_count;
  fetch_entry_t   fifo_head;
  fetch_entry_t   fifo_push_data;
  fetch_entry_t   q_head;
  fetch_entry_t   q_push_data;
  logic           unused_q_instr;

  assign handshake      = instr_req_o & instr_gnt_i;
  assign hold           = instr_req_o & ~instr_gnt_i;
  // q_valid mirrors outstanding != 0; a stray rvalid is simply ignored
  assign resp           = instr_rvalid_i & q_valid;
  assign fifo_push      = resp & (discard == '0);
  assign fifo_pop       = fetch_valid_o & fetch_ready_i & ~redirect_i;
  assign fifo_push_data = '{pc: q_head.pc, instr: instr_rdata_i};
  assign q_push_data    = '{pc: instr_addr_o, instr: 32'd0};
  assign target         = word_align(redirect_pc_i);
  assign fetch_instr_o  = fifo_head.instr;
  assign fetch_pc_o     = fifo_head.pc;
  assign unused_q_instr = ^q_head.instr;

  always_comb begin
    outstanding_next = outstanding + OW'(handshake) - OW'(resp);
    fifo_count_next  = redirect_i ? '0 : fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);
    // Everything still in flight after a redirect belongs to the old path
    if (redirect_i) begin
      discard_next = outstanding_next;
    end else begin
      discard_next = discard - OW'(resp && (discard != '0)) + OW'(handshake && pending_redirect);
    end
    pc_next = pc;
    if (redirect_i && !hold) begin
      pc_next = target;
    end else if (handshake) begin
      pc_next = pending_redirect ? redirect_target : pc + 32'd4;
    end
    credit = (32'(outstanding_next) < MAX_OUTSTANDING) &&
             ((32'(fifo_count_next) + 32'(outstanding_next)) < FIFO_DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc               <= BOOT_ADDR;
      outstanding      <= '0;
      discard          <= '0;
      pending_redirect <= 1'b0;
      redirect_target  <= BOOT_ADDR;
      instr_req_o      <= 1'b0;
      instr_addr_o     <= BOOT_ADDR;
    end else begin
      pc          <= pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (redirect_i && hold) begin
        pending_redirect <= 1'b1;
        redirect_target  <= target;
      end else if (handshake || redirect_i) begin
        pending_redirect <= 1'b0;
      end
      // A presented but ungranted request is never retracted or changed
      if (hold) begin
        instr_req_o <= 1'b1;
      end else begin
        instr_req_o  <= credit;
        instr_addr_o <= pc_next;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fetch_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .valid     (fetch_valid_o),
    .count     (fifo_count)
  );

  fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_addr_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (handshake),
    .push_data (q_push_data),
    .pop       (resp),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  always @(posedge clock) begin
    if (!reset) begin
      assert (!(instr_rvalid_i && (outstanding == '0)));
      assert (32'(outstanding) <= MAX_OUTSTANDING);
      assert (q_count == outstanding);
    end
  end

endmodule

// File: tb/tb_instr_fetch_obi.sv
// tb/tb_instr_fetch_obi.sv - randomized self-checking bench for instr_fetch_obi
module tb_instr_fetch_obi;

  localparam logic [31:0] BOOT  = 32'h8000_0000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_ready_i;

  instr_fetch_obi dut (
    .clock          (clock),
    .reset          (reset),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_instr_o  (fetch_instr_o),
    .fetch_pc_o     (fetch_pc_o),
    .fetch_ready_i  (fetch_ready_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_m, occ_m, delivered;
  logic [31:0] exp_issue, exp_deliver, pend_tgt;
  bit          pend, prev_hold;
  logic [31:0] prev_addr;
  int          gnt_mode, ready_mode, rv_mode, lat_max, redir_pct;
  bit          redir_now;
  logic [31:0] redir_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    out_m = 0; occ_m = 0; pend = 0; prev_hold = 0;
    exp_issue = BOOT; exp_deliver = BOOT; pend_tgt = BOOT;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(instr_req_o), 32'd0);
    check({tag, "_addr"}, instr_addr_o, BOOT);
    check({tag, "_valid"}, 32'(fetch_valid_o), 32'd0);
    check({tag, "_instr"}, fetch_instr_o, 32'd0);
    check({tag, "_pc"}, fetch_pc_o, 32'd0);
  endtask

  function automatic bit pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return $urandom_range(0, 3) != 0;
  endfunction

  // One cycle: check outputs at negedge, drive inputs, update the model, advance.
  task automatic step();
    bit          gnt, rdy, rv, rd, hs, hold_now, pop;
    logic [31:0] tgt, al;
    mreq_t       e;
    if (prev_hold) begin
      check("req_hold", 32'(instr_req_o), 32'd1);
      check("addr_hold", instr_addr_o, prev_addr);
    end else if (instr_req_o) begin
      check("credit_out", 32'(out_m < MAXO), 32'd1);
      check("credit_fifo", 32'(occ_m + out_m < DEPTH), 32'd1);
    end
    check("fetch_valid", 32'(fetch_valid_o), 32'(occ_m != 0));

    gnt = pick(gnt_mode);
    rdy = pick(ready_mode);
    rv  = (mq.size() > 0) && (mq[0].due <= cyc) && (rv_mode != 0) && pick(rv_mode);
    rd  = redir_now || ((redir_pct > 0) && ($urandom_range(0, 99) < redir_pct));
    tgt = redir_now ? redir_tgt : $urandom;
    al  = {tgt[31:2], 2'b00};
    instr_gnt_i    = gnt;
    fetch_ready_i  = rdy;
    instr_rvalid_i = rv;
    instr_rdata_i  = rv ? (mq[0].addr ^ 32'hFFFF_FFFF) : $urandom;
    redirect_i     = rd;
    redirect_pc_i  = tgt;
    redir_now      = 1'b0;

    hs       = instr_req_o && gnt;
    hold_now = instr_req_o && !gnt;
    if (rv) begin
      e = mq.pop_front();
      out_m--;
      if (!e.stale) occ_m++;
    end
    pop = fetch_valid_o && rdy && !rd;
    if (pop) begin
      check("fetch_pc", fetch_pc_o, exp_deliver);
      check("fetch_instr", fetch_instr_o, exp_deliver ^ 32'hFFFF_FFFF);
      exp_deliver = exp_deliver + 32'd4;
      occ_m--;
      delivered++;
    end
    if (hs) begin
      check("issue_addr", instr_addr_o, exp_issue);
      mq.push_back('{addr: instr_addr_o, stale: pend, due: cyc + 1 + int'($urandom_range(0, lat_max))});
      out_m++;
    end
    if (rd) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      occ_m = 0;
      exp_deliver = al;
      if (hold_now) begin
        pend = 1'b1;
        pend_tgt = al;
      end else begin
        pend = 1'b0;
        exp_issue = al;
      end
    end else if (hs) begin
      exp_issue = pend ? pend_tgt : instr_addr_o + 32'd4;
      pend = 1'b0;
    end
    prev_hold = hold_now;
    prev_addr = instr_addr_o;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string tag, input int bound);
    for (int i = 0; i < bound && !fetch_valid_o; i++) step();
    check({tag, "_valid"}, 32'(fetch_valid_o), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    reset          = 1'b1;
    instr_gnt_i    = 1'b1;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hDEAD_BEEF;
    redirect_i     = 1'b0;
    fetch_ready_i  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs(tag);
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs(tag);
    reset = 1'b0;
    instr_rvalid_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] held;
    int          d0;
    reset = 1'b1; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
    redirect_i = 0; redirect_pc_i = 0; fetch_ready_i = 0;
    delivered = 0; redir_now = 0; redir_tgt = 0; redir_pct = 0;
    model_reset();
    @(negedge clock);
    do_reset("rst0");

    // sequential fetch, decode always ready
    gnt_mode = 2; ready_mode = 1; rv_mode = 2; lat_max = 1;
    run(40);
    check("progress_a", 32'(delivered >= 10), 32'd1);

    // decode stalled: FIFO fills and requests stop
    gnt_mode = 1; ready_mode = 0; rv_mode = 1; lat_max = 0;
    run(10);
    check("stall_req_off", 32'(instr_req_o), 32'd0);
    check("stall_full_valid", 32'(fetch_valid_o), 32'd1);
    ready_mode = 1;
    step();
    ready_mode = 0;
    check("req_resume", 32'(instr_req_o), 32'd1);

    // redirect with two responses in flight
    rv_mode = 0;
    for (int i = 0; i < 20 && out_m < 2; i++) begin
      ready_mode = (occ_m + out_m >= DEPTH) ? 1 : 0;
      step();
    end
    check("setup_c_out", 32'(out_m), 32'd2);
    ready_mode = 0;
    redir_now = 1; redir_tgt = 32'h8000_0100;
    step();
    rv_mode = 2; lat_max = 1; gnt_mode = 2;
    wait_valid("redir_c", 40);
    check("redir_c_pc", fetch_pc_o, 32'h8000_0100);
    ready_mode = 1;
    run(12);

    // redirect while a request waits for grant
    gnt_mode = 0;
    for (int i = 0; i < 20 && !instr_req_o; i++) step();
    check("pend_req", 32'(instr_req_o), 32'd1);
    held = instr_addr_o;
    redir_now = 1; redir_tgt = 32'h8000_0200;
    run(4);
    check("pend_addr_stable", instr_addr_o, held);
    gnt_mode = 1;
    step();
    check("pend_next_addr", instr_addr_o, 32'h8000_0200);
    ready_mode = 0;
    wait_valid("redir_d", 40);
    check("redir_d_pc", fetch_pc_o, 32'h8000_0200);
    ready_mode = 1;
    run(10);

    // unaligned target at the top of memory wraps to zero
    gnt_mode = 2;
    redir_now = 1; redir_tgt = 32'hFFFF_FFFE;
    step();
    ready_mode = 0;
    wait_valid("wrap_a", 40);
    check("wrap_pc_top", fetch_pc_o, 32'hFFFF_FFFC);
    check("wrap_instr_top", fetch_instr_o, 32'h0000_0003);
    ready_mode = 1;
    step();
    ready_mode = 0;
    wait_valid("wrap_b", 40);
    check("wrap_pc_zero", fetch_pc_o, 32'h0000_0000);

    // fully random traffic with random redirects
    gnt_mode = 2; ready_mode = 2; rv_mode = 2; lat_max = 3; redir_pct = 3;
    run(400);
    redir_pct = 0;

    // reset in the middle of a burst
    gnt_mode = 1; ready_mode = 0; rv_mode = 0;
    for (int i = 0; i < 20 && out_m < 2; i++) step();
    check("setup_g_out", 32'(out_m), 32'd2);
    do_reset("rst_mid");
    d0 = delivered;
    gnt_mode = 2; ready_mode = 1; rv_mode = 2; lat_max = 1;
    run(40);
    check("restart_progress", 32'(delivered > d0 + 5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
